arch_state_dumper: RTL and testbench

Hardware counterpart to the simulation-side state display: on request, it freezes the single-cycle CPU and streams its architectural state out as tagged 32-bit beats over a valid/ready interface. The stream is the PC, then all 32 registers, then the low data-memory words, then an end marker. It sits beside `Simple_Single_CPU`. It drives a spare read port on the register file and on data memory, and a stall input on the CPU. The consumer is a UART/JTAG bridge or a bench monitor.

---
 rtl/arch_state_dumper_if.sv | 23 ++
 rtl/arch_state_dumper.sv | 140 ++++++++++++++
 tb/tb_arch_state_dumper.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arch_state_dumper_if.sv
// Output beat stream of the architectural state dumper: a tagged 32-bit
// payload moved with a valid/ready handshake.
interface arch_state_dumper_if;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_data_o;
   logic [7:0]  out_tag_o;

   // The dumper drives beats and the consumer drives ready
   modport master (
      output out_valid_o,
      output out_data_o,
      output out_tag_o,
      input  out_ready_i
   );

   modport slave (
      input  out_valid_o,
      input  out_data_o,
      input  out_tag_o,
      output out_ready_i
   );
endinterface

// File: rtl/arch_state_dumper.sv
// Architectural state dumper: on request, stalls the single-cycle CPU and
// streams PC, all 32 registers, the low data-memory words and an end marker
// as tagged beats. The register file and data memory are read through spare
// combinational ports, so each beat is loaded at the edge where its read
// data is sampled.
module arch_state_dumper #(
   parameter int MEM_WORDS = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 dump_start_i,
   input  logic [31:0]          pc_i,
   output logic [4:0]           rf_raddr_o,
   input  logic [31:0]          rf_rdata_i,
   output logic [31:0]          dm_raddr_o,
   input  logic [31:0]          dm_rdata_i,
   output logic                 cpu_stall_o,
   arch_state_dumper_if.master  stream,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam logic [5:0]  LAST_MEM = 6'(MEM_WORDS - 1);
   localparam logic [31:0] END_DATA = 32'(33 + MEM_WORDS);
   localparam logic [7:0]  END_TAG  = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REG,
      S_MEM,
      S_END
   } state_t;

   state_t      state;
   logic [5:0]  idx;
   logic        valid_q;
   logic [31:0] data_q;
   logic [7:0]  tag_q;
   logic        stall_q;
   logic        busy_q;
   logic        done_q;
   logic        slot_free;
   logic        end_accepted;

   assign stream.out_valid_o = valid_q;
   assign stream.out_data_o  = data_q;
   assign stream.out_tag_o   = tag_q;
   assign cpu_stall_o        = stall_q;
   assign busy_o             = busy_q;
   assign done_o             = done_q;

   // A new beat may be loaded when the output register is empty or is being
   // consumed at this edge; the end beat leaving ends the dump.
   always_comb begin
      slot_free    = !valid_q || stream.out_ready_i;
      end_accepted = valid_q && stream.out_ready_i && (tag_q == END_TAG);
   end

   // Read addresses follow the beat index and are parked at 0 outside their phase
   always_comb begin
      rf_raddr_o = 5'd0;
      dm_raddr_o = 32'd0;
      if (state == S_REG) begin
         rf_raddr_o = idx[4:0];
      end
      if (state == S_MEM) begin
         dm_raddr_o = {24'd0, idx, 2'b00};
      end
   end

   // Dump sequencer: walks PC, registers, memory words and end marker, loading
   // one beat per free output slot and holding everything under backpressure.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         idx     <= 6'd0;
         valid_q <= 1'b0;
         data_q  <= 32'd0;
         tag_q   <= 8'd0;
         stall_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (dump_start_i) begin
                  data_q  <= pc_i;
                  tag_q   <= 8'h00;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  stall_q <= 1'b1;
                  idx     <= 6'd0;
                  state   <= S_REG;
               end
            end
            S_REG: begin
               if (slot_free) begin
                  data_q <= rf_rdata_i;
                  tag_q  <= {2'b01, idx};
                  if (idx == 6'd31) begin
                     idx   <= 6'd0;
                     state <= S_MEM;
                  end else begin
                     idx <= idx + 6'd1;
                  end
               end
            end
            S_MEM: begin
               if (slot_free) begin
                  data_q <= dm_rdata_i;
                  tag_q  <= {2'b10, idx};
                  if (idx == LAST_MEM) begin
                     idx   <= 6'd0;
                     state <= S_END;
                  end else begin
                     idx <= idx + 6'd1;
                  end
               end
            end
            S_END: begin
               if (end_accepted) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  stall_q <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= S_IDLE;
               end else if (slot_free) begin
                  data_q <= END_DATA;
                  tag_q  <= END_TAG;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arch_state_dumper.sv
// Bench for arch_state_dumper: two instances (32 and 4 memory words) share
// register-file and data-memory models. Each dump is predicted as a list of
// beats built straight from the stream ordering and compared beat by beat,
// together with stall/busy/done and the read addresses expected for the
// next beat to be fetched.
module tb_arch_state_dumper;

   logic        clk = 1'b0;
   logic        rst;
   logic        start32;
   logic        start4;
   logic        ready;
   logic [31:0] pc;
   logic [31:0] rf [32];
   logic [31:0] dm [64];

   logic [4:0]  rfAddr32, rfAddr4;
   logic [31:0] rfData32, rfData4;
   logic [31:0] dmAddr32, dmAddr4;
   logic [31:0] dmData32, dmData4;
   logic        stall32, stall4, busy32, busy4, done32, done4;

   arch_state_dumper_if if32 ();
   arch_state_dumper_if if4 ();

   int          testCount = 0;
   int          failCount = 0;
   logic [39:0] expQ [$];
   bit          sel = 1'b0;

   logic        sValid, sStall, sBusy, sDone;
   logic [7:0]  sTag;
   logic [31:0] sData, sDm;
   logic [4:0]  sRf;

   always #5 clk = ~clk;

   assign if32.out_ready_i = ready;
   assign if4.out_ready_i  = ready;
   assign rfData32 = rf[rfAddr32];
   assign rfData4  = rf[rfAddr4];
   assign dmData32 = dm[dmAddr32[7:2]];
   assign dmData4  = dm[dmAddr4[7:2]];

   arch_state_dumper #(.MEM_WORDS(32)) dut32 (
      .clk_i(clk), .rst_i(rst), .dump_start_i(start32), .pc_i(pc),
      .rf_raddr_o(rfAddr32), .rf_rdata_i(rfData32),
      .dm_raddr_o(dmAddr32), .dm_rdata_i(dmData32),
      .cpu_stall_o(stall32), .stream(if32.master),
      .busy_o(busy32), .done_o(done32)
   );

   arch_state_dumper #(.MEM_WORDS(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .dump_start_i(start4), .pc_i(pc),
      .rf_raddr_o(rfAddr4), .rf_rdata_i(rfData4),
      .dm_raddr_o(dmAddr4), .dm_rdata_i(dmData4),
      .cpu_stall_o(stall4), .stream(if4.master),
      .busy_o(busy4), .done_o(done4)
   );

   // Observe whichever instance the current scenario is exercising
   always_comb begin
      sValid = sel ? if4.out_valid_o : if32.out_valid_o;
      sTag   = sel ? if4.out_tag_o   : if32.out_tag_o;
      sData  = sel ? if4.out_data_o  : if32.out_data_o;
      sStall = sel ? stall4          : stall32;
      sBusy  = sel ? busy4           : busy32;
      sDone  = sel ? done4           : done32;
      sRf    = sel ? rfAddr4         : rfAddr32;
      sDm    = sel ? dmAddr4         : dmAddr32;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected stream: PC, 32 registers, mw memory words, end marker carrying the beat count minus one
   task automatic buildModel(input int mw, input logic [31:0] pcv);
      expQ.delete();
      expQ.push_back({8'h00, pcv});
      for (int i = 0; i < 32; i++) expQ.push_back({8'(64 + i), rf[i]});
      for (int i = 0; i < mw; i++) expQ.push_back({8'(128 + i), dm[i]});
      expQ.push_back({8'hFF, 32'(33 + mw)});
   endtask

   function automatic logic readyFor(input int mode, input int n);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (n % 4 == 0) || (n % 4 == 3);
      return 1'($urandom_range(1, 0));
   endfunction

   task automatic fillDirected();
      for (int i = 0; i < 32; i++) rf[i] = 32'(i + 100);
      for (int i = 0; i < 64; i++) dm[i] = 32'(i * 3);
   endtask

   task automatic fillRandom();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      for (int i = 0; i < 64; i++) dm[i] = $urandom;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_valid"}, 64'(sValid), 64'd0);
      checkOutput({tag, "_stall"}, 64'(sStall), 64'd0);
      checkOutput({tag, "_busy"},  64'(sBusy),  64'd0);
      checkOutput({tag, "_done"},  64'(sDone),  64'd0);
      checkOutput({tag, "_tag"},   64'(sTag),   64'd0);
      checkOutput({tag, "_data"},  64'(sData),  64'd0);
      checkOutput({tag, "_rf"},    64'(sRf),    64'd0);
      checkOutput({tag, "_dm"},    64'(sDm),    64'd0);
   endtask

   task automatic idleCheck(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput("idle_valid", 64'(sValid), 64'd0);
         checkOutput("idle_busy",  64'(sBusy),  64'd0);
         checkOutput("idle_stall", 64'(sStall), 64'd0);
         checkOutput("idle_done",  64'(sDone),  64'd0);
      end
   endtask

   task automatic setStart(input bit s, input logic v);
      if (s) start4 = v;
      else   start32 = v;
   endtask

   // Runs one dump on the selected instance and checks every cycle until the done cycle
   task automatic applyStimulus(input bit s, input int mode, input logic [31:0] pcv,
                                input bit b2b, input bit holdStart, input bit busyPulses,
                                input int abortAt);
      int mw;
      int hs;
      int total;
      int k;
      bit finished;
      bit prevHold;
      logic [39:0] prevBeat;
      logic [39:0] want;
      logic [4:0]  eRf;
      logic [31:0] eDm;
      mw = s ? 4 : 32;
      sel = s;
      buildModel(mw, pcv);
      total = expQ.size();
      hs = 0;
      finished = 1'b0;
      prevHold = 1'b0;
      prevBeat = '0;
      if (!b2b) begin
         @(posedge clk);
         #1;
      end
      pc = pcv;
      setStart(s, 1'b1);
      @(posedge clk);
      #1;
      if (!holdStart) setStart(s, 1'b0);
      ready = readyFor(mode, 0);
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         k = hs + 1;
         eRf = (k >= 1 && k <= 32) ? 5'(k - 1) : 5'd0;
         eDm = (k >= 33 && k < 33 + mw) ? 32'(4 * (k - 33)) : 32'd0;
         checkOutput("valid", 64'(sValid), 64'd1);
         checkOutput("stall", 64'(sStall), 64'd1);
         checkOutput("busy",  64'(sBusy),  64'd1);
         checkOutput("done_early", 64'(sDone), 64'd0);
         checkOutput("rf_raddr", 64'(sRf), 64'(eRf));
         checkOutput("dm_raddr", 64'(sDm), 64'(eDm));
         if (prevHold) checkOutput("hold_beat", 64'({sTag, sData}), 64'(prevBeat));
         if (sValid && ready) begin
            want = (expQ.size() > 0) ? expQ.pop_front() : 40'hxx_xxxx_xxxx;
            checkOutput($sformatf("beat%0d", hs), 64'({sTag, sData}), 64'(want));
            hs++;
         end
         prevHold = sValid && !ready;
         prevBeat = {sTag, sData};
         if (abortAt > 0 && hs == abortAt) begin
            #2;
            rst = 1'b1;
            #1;
            checkAllZero("abort");
            @(posedge clk);
            #1;
            rst = 1'b0;
            setStart(s, 1'b0);
            idleCheck(5);
            return;
         end
         if (hs == total) begin
            finished = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         ready = readyFor(mode, cyc + 1);
         if (busyPulses) setStart(s, (hs == 5 || hs == 40) ? 1'b1 : 1'b0);
      end
      if (!finished) begin
         checkOutput("timeout", 64'd0, 64'd1);
         return;
      end
      @(posedge clk);
      #1;
      if (!holdStart) setStart(s, 1'b0);
      @(negedge clk);
      checkOutput("done",       64'(sDone),  64'd1);
      checkOutput("done_stall", 64'(sStall), 64'd0);
      checkOutput("done_busy",  64'(sBusy),  64'd0);
      checkOutput("done_valid", 64'(sValid), 64'd0);
   endtask

   // Scenario sequence
   initial begin
      rst     = 1'b0;
      start32 = 1'b0;
      start4  = 1'b0;
      ready   = 1'b0;
      pc      = 32'd0;
      fillDirected();

      #13;
      rst = 1'b1;
      #1;
      sel = 1'b0;
      checkAllZero("reset32");
      sel = 1'b1;
      checkAllZero("reset4");
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idleCheck(10);

      applyStimulus(1'b0, 0, 32'h40, 1'b0, 1'b0, 1'b0, 0);
      idleCheck(3);
      applyStimulus(1'b0, 1, 32'h40, 1'b0, 1'b0, 1'b0, 0);
      idleCheck(3);
      applyStimulus(1'b0, 0, 32'h1234, 1'b0, 1'b0, 1'b1, 0);
      idleCheck(5);

      applyStimulus(1'b0, 0, 32'hA000, 1'b0, 1'b1, 1'b0, 0);
      applyStimulus(1'b0, 0, 32'hB000, 1'b1, 1'b0, 1'b0, 0);
      idleCheck(3);

      applyStimulus(1'b0, 0, 32'hC0DE, 1'b0, 1'b0, 1'b0, 40);
      fillRandom();
      applyStimulus(1'b0, 2, $urandom, 1'b0, 1'b0, 1'b0, 0);
      idleCheck(3);

      fillDirected();
      applyStimulus(1'b1, 0, 32'h80, 1'b0, 1'b0, 1'b0, 0);
      idleCheck(3);

      for (int r = 0; r < 4; r++) begin
         fillRandom();
         applyStimulus(1'(r % 2), 2, $urandom, 1'b0, 1'b0, 1'b0, 0);
         idleCheck(2);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
